// File: rtl/seq_div5_pkg.sv
// seq_div5_pkg -- shared definitions for the seq_div5 sequential divider.
//   state_e        : controller states (IDLE, RUN, DONE)
//   cnt_width()    : width of the step counter for a given operand width
//   CNT_W          : step counter width for the default 5-bit divider
//   DIV0_QUOTIENT  : all-ones quotient returned for a zero divisor
//                    (slice the low WIDTH bits)
package seq_div5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(5);

  localparam logic [31:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_div5_div_step.sv
// seq_div5_div_step -- one combinational restoring-division step (div_step).
// Ports:
//   rem_i     [WIDTH-1:0] partial remainder entering the step
//   bit_i                 next dividend bit (MSB first)
//   divisor_i [WIDTH-1:0] divisor magnitude
//   rem_o     [WIDTH-1:0] partial remainder leaving the step
//   q_bit_o               quotient bit produced by this step
module seq_div5_div_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;

  // rem_i < divisor_i always holds, so partial < 2*divisor and the
  // WIDTH+1-bit trial difference lies in (-2^WIDTH, 2^WIDTH): its top bit
  // is exactly the sign of the true difference.
  assign partial = {rem_i, bit_i};
  assign trial   = partial - {1'b0, divisor_i};

  assign q_bit_o = ~trial[WIDTH];
  assign rem_o   = q_bit_o ? trial[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/seq_div5.sv
// seq_div5 -- sequential restoring divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIV5_SIGNED_EN (two's complement operands,
// quotient truncated toward zero, remainder takes the dividend's sign).
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   start                 launch request (only looked at while busy=0)
//   dividend, divisor     operands, captured on the accepting edge
//   busy                  high exactly while in RUN
//   done                  one-cycle completion pulse (state DONE)
//   quotient, remainder   results, held until the next completion
//   div_by_zero           set with done when the divisor was zero
//
// Handshake: an edge with start=1 and busy=0 (IDLE or DONE) accepts the
// operands; busy rises for the WIDTH steps of a normal division and done
// pulses for one cycle when the results update. Zero divisors skip RUN and
// complete on the next cycle. start while busy=1 is ignored.
module seq_div5
  import seq_div5_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // Dividend bits leave from the MSB while quotient bits enter at the LSB.
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] raw_quo;
  logic [WIDTH-1:0] fin_quo, fin_rem;
  logic [WIDTH-1:0] cap_dvd, cap_dsr;

  seq_div5_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (shift_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  assign raw_quo = {shift_q[WIDTH-2:0], step_bit};

`ifdef SEQ_DIV5_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  // The core divides magnitudes; the most-negative value keeps its bit
  // pattern, which reads correctly as an unsigned magnitude.
  assign cap_dvd = dividend[WIDTH-1] ? -dividend : dividend;
  assign cap_dsr = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign fin_quo = neg_quo_q ? -raw_quo  : raw_quo;
  assign fin_rem = neg_rem_q ? -step_rem : step_rem;
`else
  assign cap_dvd = dividend;
  assign cap_dsr = divisor;
  assign fin_quo = raw_quo;
  assign fin_rem = step_rem;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef SEQ_DIV5_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif
    unique case (state_q)
      RUN: begin
        rem_d   = step_rem;
        shift_d = raw_quo;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d     = DONE;
          quotient_d  = fin_quo;
          remainder_d = fin_rem;
          dbz_d       = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new launch.
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = DIV0_QUOTIENT[WIDTH-1:0];
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            count_d = CNT_INIT;
            rem_d   = '0;
            shift_d = cap_dvd;
            dsr_d   = cap_dsr;
`ifdef SEQ_DIV5_SIGNED_EN
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
`endif
          end
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_DIV5_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_DIV5_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
